// File: rtl/shift_arbiter_pkg.sv
// Shared constants, state/op encodings and bit-manipulation helpers for the
// two-requester shared-shifter arbiter.
package shift_arbiter_pkg;

    localparam int WIDTH = 32;
    localparam int AMT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic OP_SRA = 1'b0;
    localparam logic OP_SLL = 1'b1;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Bits left set survive; the top amt bits (sign fill of the reversed operand) are cleared.
    function automatic logic [WIDTH-1:0] sll_keep_mask(input logic [AMT_W-1:0] amt);
        return {WIDTH{1'b1}} >> amt;
    endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/result bundle between the issue paths, the arbiter and the writeback mux.
interface shift_arbiter_if;
    import shift_arbiter_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [AMT_W-1:0] req0_amt;
    logic             req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [AMT_W-1:0] req1_amt;
    logic             req1_op;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;

    modport master (
        output req0_valid, req0_data, req0_amt, req0_op,
        output req1_valid, req1_data, req1_amt, req1_op,
        output res_ready,
        input  req0_ready, req1_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_op,
        input  req1_valid, req1_data, req1_amt, req1_op,
        input  res_ready,
        output req0_ready, req1_ready, res_valid, res_data, res_id
    );

endinterface

// File: rtl/barrel_shift_right.sv
// 32-bit arithmetic right barrel shifter; the fill bit is A[31].
module barrel_shift_right (
    input  logic [31:0] A,
    input  logic [4:0]  amt,
    output logic [31:0] Out
);

    // Sign-filling right shift by amt positions.
    always_comb begin
        Out = 32'($signed(A) >>> amt);
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one arithmetic right shifter between two requesters;
// SLL is formed by bit-reversing around the shifter and masking off the sign fill.
module shift_arbiter
    import shift_arbiter_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    shift_arbiter_if.slave bus
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             op_q, op_d;
    logic             id_q, id_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_id_q, res_id_d;

    logic             grant_s;
    logic             grant_id_s;
    logic [WIDTH-1:0] shift_in_s;
    logic [WIDTH-1:0] shift_out_s;
    logic [WIDTH-1:0] result_s;

    barrel_shift_right u_shifter (
        .A   (shift_in_s),
        .amt (amt_q),
        .Out (shift_out_s)
    );

    // Arbitration: only in IDLE, ties go to the requester not granted last.
    always_comb begin
        grant_s    = 1'b0;
        grant_id_s = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_s    = 1'b1;
                grant_id_s = ~last_grant_q;
            end else if (bus.req0_valid) begin
                grant_s    = 1'b1;
                grant_id_s = 1'b0;
            end else if (bus.req1_valid) begin
                grant_s    = 1'b1;
                grant_id_s = 1'b1;
            end else begin
                grant_s    = 1'b0;
                grant_id_s = 1'b0;
            end
        end else begin
            grant_s    = 1'b0;
            grant_id_s = 1'b0;
        end
        bus.req0_ready = grant_s & ~grant_id_s;
        bus.req1_ready = grant_s & grant_id_s;
    end

    // Shared datapath: reverse in and out for SLL, masking the sign fill to zero.
    always_comb begin
        shift_in_s = data_q;
        result_s   = shift_out_s;
        if (op_q == OP_SLL) begin
            shift_in_s = bitrev(data_q);
            result_s   = bitrev(shift_out_s & sll_keep_mask(amt_q));
        end else begin
            shift_in_s = data_q;
            result_s   = shift_out_s;
        end
    end

    // Next-state and register-update logic of the IDLE/EXEC/HOLD sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        amt_d        = amt_q;
        op_d         = op_q;
        id_d         = id_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    data_d       = grant_id_s ? bus.req1_data : bus.req0_data;
                    amt_d        = grant_id_s ? bus.req1_amt  : bus.req0_amt;
                    op_d         = grant_id_s ? bus.req1_op   : bus.req0_op;
                    id_d         = grant_id_s;
                    last_grant_d = grant_id_s;
                    state_d      = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                res_data_d  = result_s;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State registers; reset leaves last_grant at 1 so requester 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            data_q       <= {WIDTH{1'b0}};
            amt_q        <= {AMT_W{1'b0}};
            op_q         <= 1'b0;
            id_q         <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= {WIDTH{1'b0}};
            res_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            amt_q        <= amt_d;
            op_q         <= op_d;
            id_q         <= id_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized and directed bench for shift_arbiter against a transaction-level
// model: grant order, result latency, held-result stability and shift values.
module tb_shift_arbiter;
    import shift_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    shift_arbiter_if bus ();

    shift_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: busy from grant until the result is consumed; result visible from age 1 on.
    bit          m_busy;
    int          m_age;
    bit          m_last;
    logic [31:0] m_res;
    bit          m_id;
    bit          acc0, acc1;
    int          grants[$];

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a, input logic op);
        if (op) return d << a;
        return 32'($signed(d) >>> a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge, advance the model at posedge, return at posedge+1.
    task automatic step();
        bit v0, v1, gnt, win, exp_rv;
        @(negedge clock);
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        gnt = 1'b0;
        win = 1'b0;
        if (!reset && !m_busy && (v0 || v1)) begin
            gnt = 1'b1;
            win = (v0 && v1) ? !m_last : !v0;
        end
        exp_rv = m_busy && (m_age >= 1);
        if (!reset) begin
            check("req0_ready", 32'(bus.req0_ready), 32'(gnt && !win));
            check("req1_ready", 32'(bus.req1_ready), 32'(gnt && win));
            check("res_valid", 32'(bus.res_valid), 32'(exp_rv));
            if (exp_rv) begin
                check("res_data", bus.res_data, m_res);
                check("res_id", 32'(bus.res_id), 32'(m_id));
            end
        end
        acc0 = gnt && !win;
        acc1 = gnt && win;
        @(posedge clock);
        if (reset) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (m_busy) begin
            if (exp_rv && bus.res_ready) m_busy = 1'b0;
            else m_age++;
        end else if (gnt) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_last = win;
            m_id   = win;
            m_res  = win ? ref_shift(bus.req1_data, bus.req1_amt, bus.req1_op)
                         : ref_shift(bus.req0_data, bus.req0_amt, bus.req0_op);
            grants.push_back(int'(win));
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_res_id", 32'(bus.res_id), 32'd0);
    endtask

    task automatic req(input int who, input logic v, input logic [31:0] d, input logic [4:0] a, input logic op);
        if (who == 0) begin
            bus.req0_valid = v; bus.req0_data = d; bus.req0_amt = a; bus.req0_op = op;
        end else begin
            bus.req1_valid = v; bus.req1_data = d; bus.req1_amt = a; bus.req1_op = op;
        end
    endtask

    // Wait (bounded) for a held result, compare to a fixed value, then consume it.
    task automatic expect_result(input string tag, input logic [31:0] d, input logic id);
        int n;
        n = 0;
        while (!bus.res_valid && n < 10) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_data"}, bus.res_data, d);
        check({tag, "_id"}, 32'(bus.res_id), 32'(id));
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        m_busy = 1'b0; m_age = 0; m_last = 1'b1; m_res = 32'd0; m_id = 1'b0;
        req(0, 1'b0, 32'd0, 5'd0, OP_SRA);
        req(1, 1'b0, 32'd0, 5'd0, OP_SRA);
        bus.res_ready = 1'b0;
        do_reset();

        // SRA with sign fill from requester 0; latency checked by the model.
        req(0, 1'b1, 32'h8000_00F0, 5'd4, OP_SRA);
        step();
        req(0, 1'b0, 32'h8000_00F0, 5'd4, OP_SRA);
        step();
        check("lat_res_valid", 32'(bus.res_valid), 32'd1);
        expect_result("sra4", 32'hF800_000F, 1'b0);

        // SLL by 31 from requester 1.
        req(1, 1'b1, 32'h0000_0001, 5'd31, OP_SLL);
        step();
        req(1, 1'b0, 32'h0, 5'd0, OP_SRA);
        expect_result("sll31", 32'h8000_0000, 1'b1);

        // amt=0 passes data through for both ops.
        req(0, 1'b1, 32'hDEAD_BEEF, 5'd0, OP_SRA);
        step();
        req(0, 1'b0, 32'h0, 5'd0, OP_SRA);
        expect_result("sra0", 32'hDEAD_BEEF, 1'b0);
        req(1, 1'b1, 32'hDEAD_BEEF, 5'd0, OP_SLL);
        step();
        req(1, 1'b0, 32'h0, 5'd0, OP_SRA);
        expect_result("sll0", 32'hDEAD_BEEF, 1'b1);

        // Both valid continuously from reset: grants alternate starting at 0.
        do_reset();
        grants.delete();
        req(0, 1'b1, 32'h1234_5678, 5'd3, OP_SLL);
        req(1, 1'b1, 32'hF000_0000, 5'd7, OP_SRA);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("alt_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) check("alt_order", 32'(grants[i]), 32'(i % 2));
        req(0, 1'b0, 32'h0, 5'd0, OP_SRA);
        req(1, 1'b0, 32'h0, 5'd0, OP_SRA);
        step();
        step();
        bus.res_ready = 1'b0;

        // Stall in HOLD with req0 waiting; the model checks stability and ready=0.
        req(1, 1'b1, 32'hCAFE_0001, 5'd8, OP_SLL);
        step();
        req(1, 1'b0, 32'h0, 5'd0, OP_SRA);
        req(0, 1'b1, 32'h0F0F_0F0F, 5'd1, OP_SRA);
        grants.delete();
        for (int i = 0; i < 12; i++) step();
        check("stall_no_grant", 32'(grants.size()), 32'd0);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        step();
        check("stall_regrant", 32'(grants.size()), 32'd1);
        req(0, 1'b0, 32'h0, 5'd0, OP_SRA);
        expect_result("stall_next", 32'h0787_8787, 1'b0);

        // Reset during EXEC aborts the op; next tie goes to requester 0.
        req(1, 1'b1, 32'h5555_AAAA, 5'd2, OP_SRA);
        step();
        req(1, 1'b0, 32'h0, 5'd0, OP_SRA);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_res_valid", 32'(bus.res_valid), 32'd0);
        grants.delete();
        req(0, 1'b1, 32'h0000_0010, 5'd4, OP_SRA);
        req(1, 1'b1, 32'h0000_0020, 5'd4, OP_SRA);
        step();
        check("abort_tie_count", 32'(grants.size()), 32'd1);
        if (grants.size() > 0) check("abort_tie_winner", 32'(grants[0]), 32'd0);
        req(0, 1'b0, 32'h0, 5'd0, OP_SRA);
        req(1, 1'b0, 32'h0, 5'd0, OP_SRA);
        expect_result("abort_next", 32'h0000_0001, 1'b0);

        // Randomized traffic with protocol-compliant requesters and a random consumer.
        for (int c = 0; c < 1500; c++) begin
            if (!bus.req0_valid || acc0 || $urandom_range(15) == 0)
                req(0, 1'($urandom_range(1)), $urandom, 5'($urandom), 1'($urandom));
            if (!bus.req1_valid || acc1 || $urandom_range(15) == 0)
                req(1, 1'($urandom_range(1)), $urandom, 5'($urandom), 1'($urandom));
            bus.res_ready = 1'($urandom_range(1));
            reset = ($urandom_range(199) == 0);
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
